// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO on a shift-register (SRL) array with first-word fall-through read.
// Optional occupancy port if_usedw is enabled by defining START_FIFO_USEDW_EN.
module linear_layer_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
`ifdef START_FIFO_USEDW_EN
    ,
    output logic [ADDR_WIDTH:0]   if_usedw
`endif
);

    localparam int             CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         rptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] srl [DEPTH];

    // Handshake: a transfer happens on a side only when request, clock enable and
    // that side's registered flag (full_n / empty_n) are all high in the same cycle.
    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read  & if_read_ce  & if_empty_n;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            count      <= count_next;
            if_empty_n <= (count_next != '0);
            if_full_n  <= (count_next != FULL_CNT);
        end
    end

    // Storage carries no reset; the oldest token sits at index count-1.
    always_ff @(posedge clk) begin
        if (push) begin
            srl[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                srl[i] <= srl[i-1];
            end
        end
    end

    assign rptr  = count - CNT_ONE;
    assign raddr = rptr[ADDR_WIDTH-1:0];

    // Empty FIFO wraps rptr past DEPTH; drive zero instead of indexing out of range.
    always_comb begin
        if_dout = '0;
        if (rptr < FULL_CNT) begin
            if_dout = srl[raddr];
        end
    end

`ifdef START_FIFO_USEDW_EN
    assign if_usedw = count;
`endif

endmodule
